// File: rtl/risc_toy_mem_pkg.sv
// risc_toy_mem_pkg: shared state, grant and read/write encodings for the RISC_TOY memory arbiter.
package risc_toy_mem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
endpackage

// File: rtl/risc_toy_mem_arbiter.sv
// risc_toy_mem_arbiter: shares one fixed-latency memory between fetch and data ports, data first with a starvation guard.
module risc_toy_mem_arbiter
  import risc_toy_mem_pkg::*;
#(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          m_req,
  output logic          m_rw,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);
  state_t state, next_state;
  gnt_t gnt, pick;
  logic [3:0] lat_cnt, starve_cnt;
  logic any_req, starve_hit;
  always_comb begin
    any_req = i_req | d_req;
    starve_hit = i_req && starve_cnt == 4'(STARVE_MAX);
    pick = (d_req && !starve_hit) ? GNT_D : GNT_I;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next_state;
  end
  always_comb begin
    next_state = state == IDLE  ? (any_req ? ISSUE : IDLE) :
                 state == ISSUE ? WAIT :
                 state == WAIT  ? (lat_cnt == 4'd1 ? DONE : WAIT) : IDLE;
  end
  // Winner's request is latched once in IDLE; later input changes are ignored until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt <= GNT_I;
      lat_cnt <= '0;
      starve_cnt <= '0;
      m_rw <= RW_READ;
      m_addr <= '0;
      m_wdata <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt <= pick;
        m_rw <= (pick == GNT_D && d_rw == RW_WRITE) ? RW_WRITE : RW_READ;
        m_addr <= pick == GNT_D ? d_addr : i_addr;
        m_wdata <= pick == GNT_D ? d_wdata : '0;
        starve_cnt <= (pick == GNT_D && i_req) ?
                      (starve_cnt == 4'(STARVE_MAX) ? starve_cnt : starve_cnt + 4'd1) : '0;
      end
      if (state == ISSUE) lat_cnt <= 4'(MEM_LAT);
      if (state == WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
        if (lat_cnt == 4'd1 && m_rw == RW_READ) begin
          if (gnt == GNT_I) i_rdata <= m_rdata;
          else d_rdata <= m_rdata;
        end
      end
    end
  end
  always_comb begin
    m_req = state == ISSUE;
    i_ack = state == DONE && gnt == GNT_I;
    d_ack = state == DONE && gnt == GNT_D;
  end
endmodule
